// File: rtl/cpu_types_pkg.sv
// Core-wide type definitions shared between datapath blocks.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/rf_pkg.sv
// Shared constants, types and port-slicing helper for the multi-port register file.
package rf_pkg;

    localparam int DW_DEF    = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0] regsel_t;

    // Low bit of port `port` inside a flattened bus of `width`-bit fields.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, release at writeback, flush clears all.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   wsel,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_sel,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_q
);

    localparam logic [NREGS-1:0] ZMASK = {{(NREGS-1){1'b0}}, (ZERO_REG != 0)};

    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;

    function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Next busy vector: reservation beats a same-cycle release, flush beats both.
    always_comb begin
        clr_mask_s = '0;
        for (int p = 0; p < NWR; p++) begin
            clr_mask_s = clr_mask_s | (wen[p] ? onehot(wsel[port_lo(p, AW) +: AW]) : '0);
        end
        set_mask_s = (rsv_en ? onehot(rsv_sel) : '0) & ~ZMASK;
        busy_d     = flush ? '0 : ((busy_q & ~clr_mask_s) | set_mask_s);
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-priority, optional
// write-to-read bypass and a busy scoreboard for hazard detection.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   wsel,
    input  logic [NWR*DW-1:0]   wdat,
    input  logic [NRD*AW-1:0]   rsel,
    output logic [NRD*DW-1:0]   rdat,
    output logic [NRD-1:0]      rbusy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_sel,
    output logic [NREGS-1:0]    busy_vec,
    input  logic                flush
);

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];
    logic [NWR-1:0] wr_en_s;

    // A write is effective unless it targets the hardwired zero register.
    always_comb begin
        wr_en_s = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_en_s[p] = wen[p] &&
                         !((ZERO_REG != 0) && (wsel[port_lo(p, AW) +: AW] == '0));
        end
    end

    // Later ports overwrite earlier ones, so the highest-numbered writer wins.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWR; p++) begin
            regs_d[wsel[port_lo(p, AW) +: AW]] =
                wr_en_s[p] ? wdat[port_lo(p, DW) +: DW] : regs_d[wsel[port_lo(p, AW) +: AW]];
        end
    end

    // Register storage.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (CLK),
        .rst_n    (nRST),
        .wen      (wen),
        .wsel     (wsel),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .flush    (flush),
        .busy_q   (busy_vec)
    );

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0] idx_s;
        logic [DW-1:0] val_s;

        assign idx_s = rsel[port_lo(r, AW) +: AW];

        // Bypass is gated by reset so rdat reads zero while nRST is low.
        always_comb begin
            val_s = regs_q[idx_s];
            for (int p = 0; p < NWR; p++) begin
                val_s = ((BYPASS != 0) && nRST && wr_en_s[p] &&
                         (wsel[port_lo(p, AW) +: AW] == idx_s))
                        ? wdat[port_lo(p, DW) +: DW] : val_s;
            end
            val_s = ((ZERO_REG != 0) && (idx_s == '0)) ? '0 : val_s;
        end

        assign rdat[port_lo(r, DW) +: DW] = val_s;
        assign rbusy[r]                   = busy_vec[idx_s];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor pops and compares.
module tb_regfile_mp;
    import cpu_types_pkg::*;
    import rf_pkg::*;

    localparam int DW = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

    logic                CLK = 1'b0;
    logic                nRST = 1'b0;
    logic [NWR-1:0]      wen = '0;
    logic [NWR*AW-1:0]   wsel = '0;
    logic [NWR*DW-1:0]   wdat = '0;
    logic [NRD*AW-1:0]   rsel = '0;
    logic                rsv_en = 1'b0;
    logic [AW-1:0]       rsv_sel = '0;
    logic                flush = 1'b0;
    logic [NRD*DW-1:0]   rdat, rdat_nb;
    logic [NRD-1:0]      rbusy, rbusy_nb;
    logic [NREGS-1:0]    busy_vec, busy_vec_nb;

    int errors = 0;
    int checks = 0;

    string        q_name[$];
    int           q_sel[$];
    logic [31:0]  q_exp[$];

    always #5 CLK = ~CLK;

    regfile_mp #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) dut (
        .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
        .rdat(rdat), .rbusy(rbusy), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .busy_vec(busy_vec), .flush(flush)
    );

    regfile_mp #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
        .rdat(rdat_nb), .rbusy(rbusy_nb), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .busy_vec(busy_vec_nb), .flush(flush)
    );

    task automatic expect_val(input string n, input int s, input logic [31:0] e);
        q_name.push_back(n);
        q_sel.push_back(s);
        q_exp.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int s);
        case (s)
            0:       return rdat[31:0];
            1:       return rdat[63:32];
            2:       return {30'b0, rbusy};
            3:       return busy_vec;
            4:       return rdat_nb[31:0];
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: compare every queued expectation against the outputs mid-cycle.
    always @(negedge CLK) begin
        while (q_name.size() > 0) begin
            string       n;
            int          s;
            logic [31:0] e;
            logic [31:0] a;
            n = q_name.pop_front();
            s = q_sel.pop_front();
            e = q_exp.pop_front();
            a = actual(s);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
            end
        end
    end

    task automatic next_cyc();
        @(posedge CLK);
        #1;
        wen    = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic set_rd(input regsel_t a, input regsel_t b);
        rsel = {b, a};
    endtask

    task automatic wr(input int p, input regsel_t s, input word_t d);
        wen[p]              = 1'b1;
        wsel[p*AW +: AW]    = s;
        wdat[p*DW +: DW]    = d;
    endtask

    task automatic rsv(input regsel_t s);
        rsv_en  = 1'b1;
        rsv_sel = s;
    endtask

    initial begin
        int budget;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Reset state on every index
        for (int i = 0; i < NREGS; i++) begin
            next_cyc();
            set_rd(regsel_t'(i), regsel_t'(NREGS - 1 - i));
            expect_val("reset_rdat0", 0, 32'h0);
            expect_val("reset_rdat1", 1, 32'h0);
            expect_val("reset_busy", 3, 32'h0);
        end

        // Basic write / read and zero register
        next_cyc(); wr(0, 5'd5, 32'hDEADBEEF); set_rd(5'd0, 5'd0);
        next_cyc(); set_rd(5'd5, 5'd5);
        expect_val("wr5_rd0", 0, 32'hDEADBEEF);
        expect_val("wr5_rd1", 1, 32'hDEADBEEF);
        expect_val("wr5_nb_rd0", 4, 32'hDEADBEEF);
        next_cyc(); wr(0, 5'd0, 32'h1); set_rd(5'd0, 5'd5);
        expect_val("zero_bypass", 0, 32'h0);
        next_cyc();
        expect_val("zero_stored", 0, 32'h0);

        // Dual write same index, bypass priority
        next_cyc(); wr(0, 5'd7, 32'hAAAA0000); wr(1, 5'd7, 32'h5555FFFF); set_rd(5'd7, 5'd0);
        expect_val("byp_prio", 0, 32'h5555FFFF);
        expect_val("nobyp_old", 4, 32'h0);
        next_cyc();
        expect_val("stored_prio", 0, 32'h5555FFFF);
        expect_val("nb_stored_prio", 4, 32'h5555FFFF);

        // Scoreboard reserve / release
        next_cyc(); rsv(5'd3); set_rd(5'd3, 5'd0);
        expect_val("rsv_same_busy", 3, 32'h0);
        expect_val("rsv_same_rbusy", 2, 32'h0);
        next_cyc();
        expect_val("rsv3_busy", 3, 32'h8);
        expect_val("rsv3_rbusy", 2, 32'h1);
        next_cyc(); wr(0, 5'd3, 32'h33);
        expect_val("wb_rbusy_held", 2, 32'h1);
        expect_val("wb_bypass", 0, 32'h33);
        next_cyc();
        expect_val("wb_cleared", 3, 32'h0);
        expect_val("wb_rbusy_clr", 2, 32'h0);
        expect_val("wb_stored", 0, 32'h33);
        next_cyc(); rsv(5'd3); wr(0, 5'd3, 32'h44);
        next_cyc();
        expect_val("rsv_wins", 3, 32'h8);
        expect_val("rsv_wins_data", 0, 32'h44);
        next_cyc(); wr(1, 5'd3, 32'h55);
        next_cyc();
        expect_val("p1_clear", 3, 32'h0);
        next_cyc(); wr(0, 5'd10, 32'h10);
        next_cyc();
        expect_val("wr_unbusy", 3, 32'h0);

        // Flush
        next_cyc(); rsv(5'd1);
        next_cyc(); rsv(5'd2);
        next_cyc(); rsv(5'd4);
        next_cyc(); flush = 1'b1; rsv(5'd6); wr(0, 5'd12, 32'h0C0C); set_rd(5'd3, 5'd12);
        expect_val("pre_flush", 3, 32'h16);
        next_cyc();
        expect_val("flushed", 3, 32'h0);
        expect_val("flush_write", 1, 32'h0C0C);
        next_cyc(); rsv(5'd0);
        next_cyc();
        expect_val("rsv_zero", 3, 32'h0);

        // Fill, then asynchronous reset between edges
        for (int i = 1; i < NREGS; i++) begin
            next_cyc(); wr(0, regsel_t'(i), 32'h1000 + i);
            if (i == NREGS - 1) rsv(5'd9);
            else rsv_en = 1'b0;
        end
        next_cyc(); set_rd(5'd31, 5'd9);
        expect_val("fill_rd31", 0, 32'h101F);
        expect_val("fill_rd9", 1, 32'h1009);
        expect_val("fill_busy", 3, 32'h200);
        expect_val("fill_rbusy", 2, 32'h2);
        next_cyc(); #1 nRST = 1'b0;
        expect_val("arst_rdat0", 0, 32'h0);
        expect_val("arst_rdat1", 1, 32'h0);
        expect_val("arst_busy", 3, 32'h0);
        expect_val("arst_rbusy", 2, 32'h0);
        expect_val("arst_nb", 4, 32'h0);
        next_cyc(); nRST = 1'b1;
        expect_val("post_rst_rdat0", 0, 32'h0);
        expect_val("post_rst_rdat1", 1, 32'h0);

        budget = 0;
        while (q_name.size() > 0 && budget < 10) begin
            @(posedge CLK);
            budget++;
        end
        if (q_name.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q_name.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
